controlador_partida: RTL and testbench

CONTROLADOR_PARTIDA -- requirements
Module: controlador_partida

---
 rtl/controlador_partida_pkg.sv | 25 ++
 rtl/controlador_partida_if.sv | 30 +++
 rtl/controlador_partida_contador_celulas.sv | 54 +++++
 rtl/controlador_partida.sv | 157 +++++++++++++++
 tb/tb_controlador_partida.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_partida_pkg.sv
// Shared types and geometry for the match controller: state codes, board size
// and the (coluna, linha) -> bit-index mapping.
package controlador_partida_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;
  localparam int CELULAS     = NUM_COLUNAS * NUM_LINHAS;

  localparam logic [1:0] MODO_PREP   = 2'b01;
  localparam logic [1:0] MODO_ATAQUE = 2'b10;

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    CONTAGEM   = 3'd2,
    ATAQUE     = 3'd3,
    VITORIA    = 3'd4,
    DERROTA    = 3'd5
  } estado_t;

  function automatic logic [5:0] indice_celula(input logic [2:0] coluna, input logic [2:0] linha);
    return 6'(coluna) * 6'(NUM_LINHAS) + 6'(linha);
  endfunction

endpackage

// File: rtl/controlador_partida_if.sv
// Player/board-side signal bundle of the match controller.
interface controlador_partida_if;
  import controlador_partida_pkg::*;

  logic [1:0]         modo;
  logic               confirmar;
  logic [2:0]         coordColuna;
  logic [2:0]         coordLinha;
  logic [CELULAS-1:0] mapa;

  logic [2:0]         estado;
  logic [CELULAS-1:0] atingido;
  logic [5:0]         acertos;
  logic [5:0]         navios;
  logic [3:0]         tiros_restantes;
  logic               LED_R;
  logic               LED_G;
  logic               LED_B;
  logic               fim;

  modport master (
    output modo, confirmar, coordColuna, coordLinha, mapa,
    input  estado, atingido, acertos, navios, tiros_restantes, LED_R, LED_G, LED_B, fim
  );

  modport slave (
    input  modo, confirmar, coordColuna, coordLinha, mapa,
    output estado, atingido, acertos, navios, tiros_restantes, LED_R, LED_G, LED_B, fim
  );
endinterface

// File: rtl/controlador_partida_contador_celulas.sv
// Serial popcount of the latched map: one cell per cycle, done is high during
// the last cell so the caller can load resultado on the same edge.
module contador_celulas
  import controlador_partida_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abortar,
  input  logic [CELULAS-1:0] dados,
  output logic               done,
  output logic [5:0]         resultado
);

  logic       ocupado_q, ocupado_d;
  logic [5:0] indice_q, indice_d;
  logic [5:0] soma_q, soma_d;
  logic       fim_varredura;

  always_comb begin
    fim_varredura = ocupado_q && (indice_q == 6'(CELULAS - 1));
    resultado     = soma_q + 6'(dados[indice_q]);
    ocupado_d     = ocupado_q;
    indice_d      = indice_q;
    soma_d        = soma_q;
    if (abortar || fim_varredura) begin
      ocupado_d = 1'b0;
      indice_d  = 6'd0;
      soma_d    = 6'd0;
    end else if (start) begin
      ocupado_d = 1'b1;
      indice_d  = 6'd0;
      soma_d    = 6'd0;
    end else if (ocupado_q) begin
      soma_d   = resultado;
      indice_d = indice_q + 6'd1;
    end
  end

  assign done = fim_varredura;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ocupado_q <= 1'b0;
      indice_q  <= 6'd0;
      soma_q    <= 6'd0;
    end else begin
      ocupado_q <= ocupado_d;
      indice_q  <= indice_d;
      soma_q    <= soma_d;
    end
  end

endmodule

// File: rtl/controlador_partida.sv
// Battleship match sequencer: latches a map, counts its ships, then scores shots.
// state      | meaning
// DESLIGADO  | off, match registers cleared
// PREPARACAO | waiting for attack mode to latch the map
// CONTAGEM   | serial ship count of the snapshot (35 cycles)
// ATAQUE     | accepting shots
// VITORIA    | all ship cells hit, outputs frozen
// DERROTA    | out of shots, outputs frozen
module controlador_partida
  import controlador_partida_pkg::*;
#(
  parameter int MAX_TIROS = 15
) (
  input logic                  clock,
  input logic                  reset_n,
  controlador_partida_if.slave bus
);

  localparam logic [3:0] TIROS_INI = 4'(MAX_TIROS);

  estado_t            estado_q, estado_d;
  logic [CELULAS-1:0] atingido_q, atingido_d;
  logic [CELULAS-1:0] snapshot_q, snapshot_d;
  logic [5:0]         acertos_q, acertos_d;
  logic [5:0]         navios_q, navios_d;
  logic [3:0]         tiros_q, tiros_d;
  logic               led_r_q, led_r_d;
  logic               led_g_q, led_g_d;
  logic               led_b_q, led_b_d;
  logic               fim_q, fim_d;

  logic       modo_off, retorno_prep, coord_valida, ja_atingida, e_navio;
  logic       inicia_contagem, aborta_contagem, cont_done;
  logic [5:0] celula, cont_resultado;

  contador_celulas u_contador (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (inicia_contagem),
    .abortar   (aborta_contagem),
    .dados     (snapshot_q),
    .done      (cont_done),
    .resultado (cont_resultado)
  );

  always_comb begin
    modo_off        = (bus.modo == 2'b00) || (bus.modo == 2'b11);
    retorno_prep    = (bus.modo == MODO_PREP) &&
                      (estado_q inside {CONTAGEM, ATAQUE, VITORIA, DERROTA});
    coord_valida    = (bus.coordColuna < 3'(NUM_COLUNAS)) && (bus.coordLinha < 3'(NUM_LINHAS));
    celula          = coord_valida ? indice_celula(bus.coordColuna, bus.coordLinha) : 6'd0;
    ja_atingida     = atingido_q[celula];
    e_navio         = snapshot_q[celula];
    aborta_contagem = (estado_q == CONTAGEM) && (bus.modo != MODO_ATAQUE);
    inicia_contagem = 1'b0;

    estado_d   = estado_q;
    atingido_d = atingido_q;
    snapshot_d = snapshot_q;
    acertos_d  = acertos_q;
    navios_d   = navios_q;
    tiros_d    = tiros_q;
    led_r_d    = led_r_q;
    led_g_d    = led_g_q;
    led_b_d    = led_b_q;

    if (modo_off) begin
      estado_d   = DESLIGADO;
      atingido_d = '0;
      snapshot_d = '0;
      acertos_d  = 6'd0;
      navios_d   = 6'd0;
      tiros_d    = TIROS_INI;
      {led_r_d, led_g_d, led_b_d} = 3'b000;
    end else if (retorno_prep) begin
      // the snapshot is kept; it is overwritten on the next attack entry
      estado_d   = PREPARACAO;
      atingido_d = '0;
      acertos_d  = 6'd0;
      navios_d   = 6'd0;
      tiros_d    = TIROS_INI;
      {led_r_d, led_g_d, led_b_d} = 3'b000;
    end else begin
      case (estado_q)
        DESLIGADO: estado_d = PREPARACAO;
        PREPARACAO: begin
          if (bus.modo == MODO_ATAQUE) begin
            snapshot_d      = bus.mapa;
            inicia_contagem = 1'b1;
            estado_d        = CONTAGEM;
          end
        end
        CONTAGEM: begin
          if (cont_done) begin
            navios_d = cont_resultado;
            estado_d = (cont_resultado == 6'd0) ? VITORIA : ATAQUE;
          end
        end
        ATAQUE: begin
          if (bus.confirmar) begin
            if (coord_valida && !ja_atingida && (tiros_q != 4'd0)) begin
              atingido_d[celula] = 1'b1;
              tiros_d = tiros_q - 4'd1;
              {led_r_d, led_g_d, led_b_d} = e_navio ? 3'b010 : 3'b100;
              if (e_navio) acertos_d = acertos_q + 6'd1;
              // a winning last shot is a victory, not a defeat
              if (e_navio && ((acertos_q + 6'd1) == navios_q)) estado_d = VITORIA;
              else if (tiros_q == 4'd1)                         estado_d = DERROTA;
            end else begin
              {led_r_d, led_g_d, led_b_d} = 3'b001;
            end
          end
        end
        default: ;
      endcase
    end

    fim_d = (estado_d == VITORIA) || (estado_d == DERROTA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= DESLIGADO;
      atingido_q <= '0;
      snapshot_q <= '0;
      acertos_q  <= 6'd0;
      navios_q   <= 6'd0;
      tiros_q    <= TIROS_INI;
      led_r_q    <= 1'b0;
      led_g_q    <= 1'b0;
      led_b_q    <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      atingido_q <= atingido_d;
      snapshot_q <= snapshot_d;
      acertos_q  <= acertos_d;
      navios_q   <= navios_d;
      tiros_q    <= tiros_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
      fim_q      <= fim_d;
    end
  end

  assign bus.estado          = estado_q;
  assign bus.atingido        = atingido_q;
  assign bus.acertos         = acertos_q;
  assign bus.navios          = navios_q;
  assign bus.tiros_restantes = tiros_q;
  assign bus.LED_R           = led_r_q;
  assign bus.LED_G           = led_g_q;
  assign bus.LED_B           = led_b_q;
  assign bus.fim             = fim_q;

endmodule

// File: tb/tb_controlador_partida.sv
// Bench for controlador_partida: shot table, directed corner sequences and a
// random run against a rule-level reference model (MAX_TIROS 15 and 3 instances).
module tb_controlador_partida;
  import controlador_partida_pkg::*;

  localparam int S_DES  = int'(DESLIGADO);
  localparam int S_PREP = int'(PREPARACAO);
  localparam int S_CONT = int'(CONTAGEM);
  localparam int S_ATQ  = int'(ATAQUE);
  localparam int S_VIT  = int'(VITORIA);
  localparam int S_DER  = int'(DERROTA);
  localparam int MAXT   = 15;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  controlador_partida_if bus();
  controlador_partida_if bus3();

  assign bus3.modo        = bus.modo;
  assign bus3.confirmar   = bus.confirmar;
  assign bus3.coordColuna = bus.coordColuna;
  assign bus3.coordLinha  = bus.coordLinha;
  assign bus3.mapa        = bus.mapa;

  controlador_partida #(.MAX_TIROS(15)) dut  (.clock(clock), .reset_n(reset_n), .bus(bus));
  controlador_partida #(.MAX_TIROS(3))  dut3 (.clock(clock), .reset_n(reset_n), .bus(bus3));

  int testes = 0;
  int falhas = 0;

  // reference model (MAX_TIROS = 15 instance)
  int          m_estado, m_acertos, m_navios, m_tiros, m_cont;
  logic [34:0] m_snap, m_ating;
  logic [2:0]  m_led;  // {R,G,B}

  function automatic void modelo_reset();
    m_estado = S_DES; m_acertos = 0; m_navios = 0; m_tiros = MAXT; m_cont = 0;
    m_snap = '0; m_ating = '0; m_led = 3'b000;
  endfunction

  function automatic void modelo_passo(input logic [1:0] m, input logic c, input int col,
                                       input int lin, input logic [34:0] mp);
    if (m == 2'b00 || m == 2'b11) begin
      modelo_reset();
    end else if (m == 2'b01 && (m_estado == S_CONT || m_estado == S_ATQ ||
                                m_estado == S_VIT || m_estado == S_DER)) begin
      m_estado = S_PREP; m_ating = '0; m_acertos = 0; m_navios = 0;
      m_tiros = MAXT; m_led = 3'b000;
    end else if (m_estado == S_DES) begin
      m_estado = S_PREP;
    end else if (m_estado == S_PREP) begin
      if (m == 2'b10) begin m_snap = mp; m_cont = 0; m_estado = S_CONT; end
    end else if (m_estado == S_CONT) begin
      m_cont++;
      if (m_cont == 35) begin
        m_navios = $countones(m_snap);
        m_estado = (m_navios == 0) ? S_VIT : S_ATQ;
      end
    end else if (m_estado == S_ATQ && c) begin
      if (col < 5 && lin < 7 && !m_ating[col*7+lin] && m_tiros > 0) begin
        m_ating[col*7+lin] = 1'b1;
        m_tiros--;
        if (m_snap[col*7+lin]) begin m_acertos++; m_led = 3'b010; end
        else m_led = 3'b100;
        if (m_acertos == m_navios) m_estado = S_VIT;
        else if (m_tiros == 0)     m_estado = S_DER;
      end else begin
        m_led = 3'b001;
      end
    end
  endfunction

  task automatic compara(input string nome);
    logic [2:0] led_dut;
    logic       fim_esp;
    led_dut = {bus.LED_R, bus.LED_G, bus.LED_B};
    fim_esp = (m_estado == S_VIT) || (m_estado == S_DER);
    testes++;
    if (int'(bus.estado) != m_estado || bus.atingido != m_ating || int'(bus.acertos) != m_acertos ||
        int'(bus.navios) != m_navios || int'(bus.tiros_restantes) != m_tiros ||
        led_dut != m_led || bus.fim != fim_esp) begin
      falhas++;
      $display("FAIL %s: dut estado=%0d ating=%h acertos=%0d navios=%0d tiros=%0d led=%b fim=%b; required estado=%0d ating=%h acertos=%0d navios=%0d tiros=%0d led=%b fim=%b",
               nome, bus.estado, bus.atingido, bus.acertos, bus.navios, bus.tiros_restantes, led_dut,
               bus.fim, m_estado, m_ating, m_acertos, m_navios, m_tiros, m_led, fim_esp);
    end
  endtask

  task automatic verifica(input string nome, input longint obtido, input longint esperado);
    testes++;
    if (obtido != esperado) begin
      falhas++;
      $display("FAIL %s: got %0d, required %0d", nome, obtido, esperado);
    end
  endtask

  task automatic ciclo(input logic [1:0] m, input logic c, input logic [2:0] col,
                       input logic [2:0] lin, input logic [34:0] mp, input string nome);
    bus.modo = m; bus.confirmar = c; bus.coordColuna = col; bus.coordLinha = lin; bus.mapa = mp;
    @(posedge clock);
    modelo_passo(m, c, int'(col), int'(lin), mp);
    @(negedge clock);
    compara(nome);
  endtask

  task automatic conta_contagem(input logic [34:0] mp, output int n);
    n = 0;
    while (int'(bus.estado) == S_CONT && n < 100) begin
      ciclo(2'b10, 1'b0, 3'd0, 3'd0, mp, "contagem");
      n++;
    end
  endtask

  typedef struct {
    logic [2:0]  col;
    logic [2:0]  lin;
    logic [2:0]  led;
    int          tiros;
    int          acertos;
    int          estado;
    logic [34:0] ating;
  } tiro_t;

  tiro_t tab[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [34:0] mapa_a, mapa_b, um, mapa_r;
    logic [63:0] r1, r2, r3;
    logic [1:0]  m;
    logic [2:0]  col, lin;
    int          n, r;

    um = 35'd1;
    mapa_a = (um << 0) | (um << 8);
    tab[0] = '{3'd0, 3'd0, 3'b010, 14, 1, S_ATQ, um};
    tab[1] = '{3'd0, 3'd0, 3'b001, 14, 1, S_ATQ, um};
    tab[2] = '{3'd6, 3'd0, 3'b001, 14, 1, S_ATQ, um};
    tab[3] = '{3'd2, 3'd3, 3'b100, 13, 1, S_ATQ, um | (um << 17)};
    tab[4] = '{3'd4, 3'd7, 3'b001, 13, 1, S_ATQ, um | (um << 17)};
    tab[5] = '{3'd1, 3'd1, 3'b010, 12, 2, S_VIT, um | (um << 17) | (um << 8)};
    tab[6] = '{3'd3, 3'd3, 3'b010, 12, 2, S_VIT, um | (um << 17) | (um << 8)};

    reset_n = 1'b0;
    bus.modo = 2'b00; bus.confirmar = 1'b0; bus.coordColuna = 3'd0; bus.coordLinha = 3'd0;
    bus.mapa = '0;
    modelo_reset();
    repeat (2) @(negedge clock);
    compara("reset");
    verifica("reset_estado", bus.estado, S_DES);
    verifica("reset_tiros", bus.tiros_restantes, 15);
    verifica("reset_tiros_max3", bus3.tiros_restantes, 3);
    reset_n = 1'b1;

    // ships at cells 0 and 8: 35 counting cycles, then ATAQUE with 2 ships
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, mapa_a, "entra_prep");
    verifica("estado_prep", bus.estado, S_PREP);
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_a, "entra_contagem");
    conta_contagem(mapa_a, n);
    verifica("ciclos_contagem", n, 35);
    verifica("navios_2", bus.navios, 2);
    verifica("estado_ataque", bus.estado, S_ATQ);

    foreach (tab[i]) begin
      ciclo(2'b10, 1'b1, tab[i].col, tab[i].lin, mapa_a, "tiro_tabela");
      verifica("tab_led", {bus.LED_R, bus.LED_G, bus.LED_B}, tab[i].led);
      verifica("tab_tiros", bus.tiros_restantes, tab[i].tiros);
      verifica("tab_acertos", bus.acertos, tab[i].acertos);
      verifica("tab_estado", bus.estado, tab[i].estado);
      verifica("tab_atingido", bus.atingido, tab[i].ating);
      ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_a, "tab_pausa");
      verifica("tab_led_mantido", {bus.LED_R, bus.LED_G, bus.LED_B}, tab[i].led);
    end

    // snapshot ignores mapa changes; modo 01 clears the match
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, mapa_a, "vit_para_prep");
    verifica("prep_acertos", bus.acertos, 0);
    verifica("prep_tiros", bus.tiros_restantes, 15);
    verifica("prep_atingido", bus.atingido, 0);
    verifica("prep_leds", {bus.LED_R, bus.LED_G, bus.LED_B}, 0);
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_a, "latch_a");
    conta_contagem(~mapa_a, n);
    verifica("snap_navios", bus.navios, 2);
    ciclo(2'b10, 1'b1, 3'd0, 3'd0, ~mapa_a, "snap_acerto");
    verifica("snap_led_g", {bus.LED_R, bus.LED_G, bus.LED_B}, 3'b010);
    ciclo(2'b10, 1'b1, 3'd2, 3'd3, ~mapa_a, "snap_erro");
    verifica("snap_led_r", {bus.LED_R, bus.LED_G, bus.LED_B}, 3'b100);
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, ~mapa_a, "limpa_prep");
    verifica("limpa_acertos", bus.acertos, 0);
    verifica("limpa_tiros", bus.tiros_restantes, 15);
    verifica("limpa_atingido", bus.atingido, 0);
    verifica("limpa_estado", bus.estado, S_PREP);

    // MAX_TIROS = 3 instance: three misses end in DERROTA
    mapa_b = (um << 0) | (um << 8) | (um << 16);
    ciclo(2'b00, 1'b0, 3'd0, 3'd0, mapa_b, "desliga");
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, mapa_b, "prep3");
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_b, "latch3");
    conta_contagem(mapa_b, n);
    verifica("max3_navios", bus3.navios, 3);
    verifica("max3_estado", bus3.estado, S_ATQ);
    ciclo(2'b10, 1'b1, 3'd4, 3'd6, mapa_b, "erro1");
    verifica("max3_tiros1", bus3.tiros_restantes, 2);
    verifica("max3_led1", {bus3.LED_R, bus3.LED_G, bus3.LED_B}, 3'b100);
    ciclo(2'b10, 1'b1, 3'd3, 3'd0, mapa_b, "erro2");
    verifica("max3_tiros2", bus3.tiros_restantes, 1);
    verifica("max3_led2", {bus3.LED_R, bus3.LED_G, bus3.LED_B}, 3'b100);
    ciclo(2'b10, 1'b1, 3'd2, 3'd0, mapa_b, "erro3");
    verifica("max3_tiros3", bus3.tiros_restantes, 0);
    verifica("max3_led3", {bus3.LED_R, bus3.LED_G, bus3.LED_B}, 3'b100);
    verifica("max3_derrota", bus3.estado, S_DER);
    verifica("max3_fim", bus3.fim, 1);
    ciclo(2'b10, 1'b1, 3'd1, 3'd0, mapa_b, "tiro_pos_derrota");
    verifica("max3_sem_wrap", bus3.tiros_restantes, 0);
    verifica("max3_segura", bus3.estado, S_DER);

    // reset during counting aborts; re-entry recounts from cell 0
    mapa_b = (um << 0) | (um << 8) | (um << 34);
    ciclo(2'b00, 1'b0, 3'd0, 3'd0, mapa_b, "desliga2");
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, mapa_b, "prep4");
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_b, "latch4");
    repeat (9) ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_b, "contagem_parcial");
    #2 reset_n = 1'b0;
    #1 modelo_reset();
    compara("reset_contagem");
    verifica("rst_estado", bus.estado, S_DES);
    verifica("rst_navios", bus.navios, 0);
    verifica("rst_tiros_max3", bus3.tiros_restantes, 3);
    @(negedge clock);
    reset_n = 1'b1;
    ciclo(2'b01, 1'b0, 3'd0, 3'd0, mapa_b, "prep5");
    ciclo(2'b10, 1'b0, 3'd0, 3'd0, mapa_b, "latch5");
    conta_contagem(mapa_b, n);
    verifica("recontagem_ciclos", n, 35);
    verifica("recontagem_navios", bus.navios, 3);

    // random run against the model
    mapa_r = mapa_b;
    for (int k = 0; k < 2500; k++) begin
      if (k % 60 == 0) begin
        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
        mapa_r = ($urandom_range(0, 9) == 0) ? 35'd0 : 35'(r1 & r2 & r3);
      end
      r = $urandom_range(0, 99);
      m = (r < 95) ? 2'b10 : (r < 97) ? 2'b01 : (r < 99) ? 2'b00 : 2'b11;
      col = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      lin = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
      ciclo(m, ($urandom_range(0, 2) == 0), col, lin, mapa_r, "aleatorio");
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
